// File: rtl/uart_rx_fifo_if.sv
// Bus between the UART byte receiver, the capture/FIFO stage and the
// system-side consumer. The slave modport is the FIFO stage's view.
interface uart_rx_fifo_if #(
    parameter int ADDR_W = 4
);
    logic [7:0]      i_rx_data;
    logic            i_rx_ready;
    logic            o_clear_ready;
    logic [7:0]      o_data;
    logic            o_valid;
    logic            i_pop;
    logic [ADDR_W:0] o_count;
    logic            o_full;
    logic            o_empty;
    logic            o_overflow;
    logic            i_clear_overflow;

    modport master (
        output i_rx_data, i_rx_ready, i_pop, i_clear_overflow,
        input  o_clear_ready, o_data, o_valid, o_count, o_full, o_empty, o_overflow
    );

    modport slave (
        input  i_rx_data, i_rx_ready, i_pop, i_clear_overflow,
        output o_clear_ready, o_data, o_valid, o_count, o_full, o_empty, o_overflow
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Captures each byte from the UART receiver's level-held ready flag exactly
// once, acknowledges it with a one-cycle clear pulse, and buffers it in a
// first-word-fall-through FIFO. Bytes arriving while full are dropped and
// flagged with a sticky overflow bit; the receiver is still acknowledged.
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic          clk,
    input  logic          i_reset,
    uart_rx_fifo_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t          state_q;
    logic            clear_q;
    logic [7:0]      mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0] count_q, count_d;
    logic            overflow_q, overflow_d;

    logic            push;
    logic            push_ok;
    logic            pop_ok;
    logic            full;
    logic            empty;

    assign full  = (count_q == (ADDR_W+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = (state_q == ST_IDLE) && bus.i_rx_ready;

    // Capture FSM: one push per ready assertion, then wait for the flag to drop.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            clear_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_rx_ready) begin
                        state_q <= ST_ACK;
                        clear_q <= 1'b1;
                    end
                end
                ST_ACK: begin
                    state_q <= ST_WAIT;
                    clear_q <= 1'b0;
                end
                ST_WAIT: begin
                    if (!bus.i_rx_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    clear_q <= 1'b0;
                end
            endcase
        end
    end

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        pop_ok     = bus.i_pop && !empty;
        push_ok    = push && (!full || pop_ok);
        wr_ptr_d   = push_ok ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop_ok  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        count_d    = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + (ADDR_W+1)'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - (ADDR_W+1)'(1);
        end
        overflow_d = overflow_q;
        if (push && !push_ok) begin
            overflow_d = 1'b1;
        end else if (bus.i_clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    // FIFO bookkeeping registers.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array; no reset needed since count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok && !i_reset) begin
            mem_q[wr_ptr_q] <= bus.i_rx_data;
        end
    end

    assign bus.o_clear_ready = clear_q;
    assign bus.o_data        = mem_q[rd_ptr_q];
    assign bus.o_valid       = !empty;
    assign bus.o_count       = count_q;
    assign bus.o_full        = full;
    assign bus.o_empty       = empty;
    assign bus.o_overflow    = overflow_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: emulates the UART receiver handshake and a
// consumer, and checks outputs against a queue-based reference model.
module tb_uart_rx_fifo;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic clk = 1'b0;
    logic i_reset;

    always #5 clk = ~clk;

    uart_rx_fifo_if #(.ADDR_W(ADDR_W)) bus ();

    uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    logic [7:0] q[$];
    bit         ovf_m;
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        bus.i_rx_data        = 8'h00;
        bus.i_rx_ready       = 1'b0;
        bus.i_pop            = 1'b0;
        bus.i_clear_overflow = 1'b0;
        i_reset = 1'b1;
        tick;
        i_reset = 1'b0;
        tick;
        q.delete();
        ovf_m = 1'b0;
    endtask

    // Receiver presents a byte, drops ready once acknowledged, then the
    // stage needs two more cycles before it can see the next byte.
    task automatic send_byte(input logic [7:0] b, input bit pop, input bit clr, output int pulses);
        bit pop_ok;
        bit push_ok;
        pulses = 0;
        bus.i_rx_data        = b;
        bus.i_rx_ready       = 1'b1;
        bus.i_pop            = pop;
        bus.i_clear_overflow = clr;
        pop_ok  = pop && (q.size() > 0);
        push_ok = (q.size() < DEPTH) || pop_ok;
        if (pop_ok) void'(q.pop_front());
        if (push_ok) q.push_back(b);
        if (!push_ok) ovf_m = 1'b1;
        else if (clr) ovf_m = 1'b0;
        tick;
        pulses += int'(bus.o_clear_ready);
        bus.i_rx_ready       = 1'b0;
        bus.i_pop            = 1'b0;
        bus.i_clear_overflow = 1'b0;
        repeat (2) begin
            tick;
            pulses += int'(bus.o_clear_ready);
        end
    endtask

    task automatic pop_one;
        bus.i_pop = 1'b1;
        if (q.size() > 0) void'(q.pop_front());
        tick;
        bus.i_pop = 1'b0;
    endtask

    task automatic idle_cycle(input bit clr);
        bus.i_clear_overflow = clr;
        if (clr) ovf_m = 1'b0;
        tick;
        bus.i_clear_overflow = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        n_checks++; if (bus.o_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.o_count); end
        n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.o_valid); end
        n_checks++; if (bus.o_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", bus.o_empty); end
        n_checks++; if (bus.o_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", bus.o_full); end
        n_checks++; if (bus.o_clear_ready !== 1'b0) begin n_fail++; $display("FAIL reset_clear: got %b expected 0", bus.o_clear_ready); end
        n_checks++; if (bus.o_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", bus.o_overflow); end
    endtask

    task automatic test_single_hold;
        int pulses;
        do_reset;
        pulses = 0;
        bus.i_rx_data  = 8'hA5;
        bus.i_rx_ready = 1'b1;
        q.push_back(8'hA5);
        repeat (10) begin
            tick;
            pulses += int'(bus.o_clear_ready);
        end
        bus.i_rx_ready = 1'b0;
        tick;
        tick;
        n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL hold_pulses: got %0d cycles high expected 1", pulses); end
        n_checks++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid: got %b expected 1", bus.o_valid); end
        n_checks++; if (bus.o_data !== 8'hA5) begin n_fail++; $display("FAIL hold_data: got %h expected a5", bus.o_data); end
        n_checks++; if (bus.o_count !== (ADDR_W+1)'(q.size())) begin n_fail++; $display("FAIL hold_count: got %0d expected %0d", bus.o_count, q.size()); end
    endtask

    task automatic test_fill_drain;
        int p;
        int bad;
        do_reset;
        for (int i = 1; i <= DEPTH; i++) send_byte(8'(i), 1'b0, 1'b0, p);
        n_checks++; if (bus.o_full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b expected 1", bus.o_full); end
        n_checks++; if (bus.o_count !== (ADDR_W+1)'(DEPTH)) begin n_fail++; $display("FAIL fill_count: got %0d expected %0d", bus.o_count, DEPTH); end
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.o_data !== 8'(i + 1)) begin
                bad++;
                $display("FAIL drain_data[%0d]: got %h expected %h", i, bus.o_data, 8'(i + 1));
            end
            pop_one;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL drain_order: %0d wrong bytes expected 0", bad); end
        n_checks++; if (bus.o_empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b expected 1", bus.o_empty); end
        n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %b expected 0", bus.o_valid); end
    endtask

    task automatic test_overflow;
        int p;
        do_reset;
        for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom), 1'b0, 1'b0, p);
        send_byte(8'h77, 1'b0, 1'b0, p);
        n_checks++; if (p != 1) begin n_fail++; $display("FAIL ovf_pulse: got %0d expected 1", p); end
        n_checks++; if (bus.o_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", bus.o_overflow); end
        n_checks++; if (bus.o_count !== (ADDR_W+1)'(q.size())) begin n_fail++; $display("FAIL ovf_count: got %0d expected %0d", bus.o_count, q.size()); end
        n_checks++; if (bus.o_data !== q[0]) begin n_fail++; $display("FAIL ovf_head: got %h expected %h", bus.o_data, q[0]); end
        idle_cycle(1'b1);
        n_checks++; if (bus.o_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", bus.o_overflow); end
        send_byte(8'h78, 1'b0, 1'b1, p);
        n_checks++; if (bus.o_overflow !== ovf_m) begin n_fail++; $display("FAIL ovf_set_wins: got %b expected %b", bus.o_overflow, ovf_m); end
        idle_cycle(1'b1);
        n_checks++; if (bus.o_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear2: got %b expected 0", bus.o_overflow); end
    endtask

    task automatic test_full_push_pop;
        int p;
        int bad;
        logic [7:0] last;
        send_byte(8'h3C, 1'b1, 1'b0, p);
        n_checks++; if (bus.o_count !== (ADDR_W+1)'(DEPTH)) begin n_fail++; $display("FAIL fpp_count: got %0d expected %0d", bus.o_count, DEPTH); end
        n_checks++; if (bus.o_overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_ovf: got %b expected 0", bus.o_overflow); end
        n_checks++; if (bus.o_data !== q[0]) begin n_fail++; $display("FAIL fpp_head: got %h expected %h", bus.o_data, q[0]); end
        bad  = 0;
        last = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.o_data !== q[0]) begin
                bad++;
                $display("FAIL fpp_data[%0d]: got %h expected %h", i, bus.o_data, q[0]);
            end
            last = bus.o_data;
            pop_one;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL fpp_order: %0d wrong bytes expected 0", bad); end
        n_checks++; if (last !== 8'h3C) begin n_fail++; $display("FAIL fpp_last: got %h expected 3c", last); end
    endtask

    task automatic test_wrap;
        int p;
        int bad;
        do_reset;
        pop_one;
        n_checks++; if (bus.o_count !== '0) begin n_fail++; $display("FAIL empty_pop_count: got %0d expected 0", bus.o_count); end
        send_byte(8'($urandom), 1'b1, 1'b0, p);
        n_checks++; if (bus.o_count !== (ADDR_W+1)'(q.size())) begin n_fail++; $display("FAIL empty_pushpop_count: got %0d expected %0d", bus.o_count, q.size()); end
        n_checks++; if (bus.o_data !== q[0]) begin n_fail++; $display("FAIL empty_pushpop_data: got %h expected %h", bus.o_data, q[0]); end
        send_byte(8'($urandom), 1'b0, 1'b0, p);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.o_data !== q[0] || bus.o_count !== 5'd2) begin
                bad++;
                $display("FAIL wrap_step[%0d]: got data %h count %0d expected %h count 2", i, bus.o_data, bus.o_count, q[0]);
            end
            send_byte(8'($urandom), 1'b1, 1'b0, p);
        end
        for (int i = 0; i < 2; i++) begin
            if (bus.o_data !== q[0]) begin
                bad++;
                $display("FAIL wrap_tail[%0d]: got %h expected %h", i, bus.o_data, q[0]);
            end
            pop_one;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL wrap_seq: %0d errors expected 0", bad); end
        n_checks++; if (bus.o_overflow !== 1'b0) begin n_fail++; $display("FAIL wrap_ovf: got %b expected 0", bus.o_overflow); end
        n_checks++; if (bus.o_empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty: got %b expected 1", bus.o_empty); end
    endtask

    task automatic test_random;
        int p;
        int bad;
        int op;
        do_reset;
        bad = 0;
        for (int i = 0; i < 120; i++) begin
            op = int'($urandom_range(0, 4));
            case (op)
                0, 1: send_byte(8'($urandom), 1'b0, ($urandom_range(0, 5) == 0), p);
                2:    send_byte(8'($urandom), 1'b1, ($urandom_range(0, 5) == 0), p);
                3:    pop_one;
                default: idle_cycle($urandom_range(0, 1) == 1);
            endcase
            if (bus.o_count !== (ADDR_W+1)'(q.size()) || bus.o_valid !== (q.size() > 0) ||
                bus.o_full !== (q.size() == DEPTH) || bus.o_empty !== (q.size() == 0) ||
                bus.o_overflow !== ovf_m || (q.size() > 0 && bus.o_data !== q[0])) begin
                bad++;
                $display("FAIL rand_step[%0d]: got count %0d ovf %b data %h expected count %0d ovf %b",
                         i, bus.o_count, bus.o_overflow, bus.o_data, q.size(), ovf_m);
            end
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rand_total: %0d errors expected 0", bad); end
    endtask

    task automatic test_reset_in_ack;
        int p;
        int pulses;
        do_reset;
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b0, 1'b0, p);
        bus.i_rx_data  = 8'hC3;
        bus.i_rx_ready = 1'b1;
        tick;
        n_checks++; if (bus.o_clear_ready !== 1'b1) begin n_fail++; $display("FAIL ack_entered: got %b expected 1", bus.o_clear_ready); end
        #2 i_reset = 1'b1;
        #1;
        q.delete();
        ovf_m = 1'b0;
        n_checks++; if (bus.o_count !== '0) begin n_fail++; $display("FAIL rst_ack_count: got %0d expected 0", bus.o_count); end
        n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ack_valid: got %b expected 0", bus.o_valid); end
        n_checks++; if (bus.o_clear_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ack_clear: got %b expected 0", bus.o_clear_ready); end
        bus.i_rx_data = 8'h5A;
        @(negedge clk);
        i_reset = 1'b0;
        q.push_back(8'h5A);
        pulses = 0;
        tick;
        pulses += int'(bus.o_clear_ready);
        bus.i_rx_ready = 1'b0;
        repeat (2) begin
            tick;
            pulses += int'(bus.o_clear_ready);
        end
        n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL post_rst_pulse: got %0d expected 1", pulses); end
        n_checks++; if (bus.o_count !== 5'd1) begin n_fail++; $display("FAIL post_rst_count: got %0d expected 1", bus.o_count); end
        n_checks++; if (bus.o_data !== 8'h5A) begin n_fail++; $display("FAIL post_rst_data: got %h expected 5a", bus.o_data); end
    endtask

    initial begin
        i_reset              = 1'b1;
        bus.i_rx_data        = 8'h00;
        bus.i_rx_ready       = 1'b0;
        bus.i_pop            = 1'b0;
        bus.i_clear_overflow = 1'b0;
        @(negedge clk);
        test_reset;
        test_single_hold;
        test_fill_drain;
        test_overflow;
        test_full_push_pop;
        test_wrap;
        test_random;
        test_reset_in_ack;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
